fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer that owns the program counter and drives the instruction-memory request/response handshake. It sits between the execute stage (branch/jump redirects), the hazard unit (stall) and instruction memory. It delivers one instruction at a time, tagged with its PC, to decode. It replaces free-running PC increment with a state machine that tolerates multi-cycle memory latency and discards stale fetches after a redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `stall` in 1: decode cannot accept; hold the current instruction output.
- `redirect` in 1: taken branch/jump from execute; highest priority.
- `redirect_target` in 32: new PC; bits [1:0] are ignored and forced to 0.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: fetch address; always equals the current PC.
- `imem_ready` in 1: memory accepts the request this cycle.
- `imem_rvalid` in 1: response data valid (one response per accepted request, in order).
- `imem_rdata` in 32: fetched instruction.
- `instr_valid` out 1: output register holds an unconsumed instruction.
- `instr` out 32: instruction to decode.
- `instr_pc` out 32: address of `instr`.
- `flush` out 1: one-cycle pulse that kills younger pipeline stages.

## Operation
- States: `BOOT`, `REQ`, `WAIT`, `HOLD`, `DROP`.
- **BOOT** (first cycle after `rst` release): `imem_req`=0, then go to `REQ`.
- **REQ**:
  - `imem_req`=1 and `imem_addr`=PC.
  - On `imem_ready`, go to `WAIT`.
- **WAIT**: on `imem_rvalid`:
  - Load `instr`/`instr_pc`/`instr_valid`=1.
  - PC <= PC+4.
  - Next state is `HOLD` if `stall`, else `REQ`.
- **HOLD**:
  - Outputs are frozen while `stall`=1.
  - On `stall`=0 the instruction is consumed; go to `REQ`.
- **Consumption rule**: an instruction is consumed on any cycle with `instr_valid`=1 and `stall`=0. On consumption, `instr_valid` clears unless a new response loads the same cycle.
- **Redirect** (any state except `BOOT`):
  - PC <= {`redirect_target`[31:2],2'b00}.
  - `instr_valid` <= 0; `flush`=1 on the next cycle.
  - If a response is outstanding (state `WAIT`, or `REQ` with `imem_ready`=1 this cycle), go to `DROP`; otherwise go to `REQ`.
- **DROP**:
  - `imem_req`=0.
  - The next `imem_rvalid` is discarded and `instr_valid` stays 0; then go to `REQ`.
  - A further redirect in `DROP` updates PC and stays in `DROP`.
- **Simultaneous events**:
  - `redirect` together with `imem_rvalid`: the response is discarded, not delivered; go to `REQ`.
  - `redirect` overrides `stall`.
- **Arithmetic**: PC+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- **Reset**:
  - Values: PC=`RESET_PC`, state=`BOOT`, `imem_req`=0, `imem_addr`=`RESET_PC`, `instr_valid`=0, `instr`=32'h0000_0013 (NOP), `instr_pc`=`RESET_PC`, `flush`=0.
  - Reset mid-operation aborts any outstanding fetch; memory is reset by the same `rst`.

## Timing
- `imem_req`, `imem_addr` and `flush` are decoded from registered state/PC only, with no combinational input-to-output paths.
- **Fetch latency**: request accepted in cycle N with `imem_rvalid` in cycle N+k (k>=1) gives `instr_valid`=1 in cycle N+k+1.
- **Throughput**: with k=1 and no stall, one instruction every 2 cycles.
- `flush` is high exactly one cycle, the cycle after `redirect` is sampled. Back-to-back redirects give back-to-back flush cycles.
- The first post-redirect request is issued no earlier than the cycle after `redirect`. If in `DROP`, it is issued the cycle after the discarded response.

## Structure
- Package `fetch_pkg`:
  - `fetch_state_t` enum (`BOOT`, `REQ`, `WAIT`, `HOLD`, `DROP`).
  - `INSTR_BYTES`=4.
  - `NOP_INSTR`=32'h0000_0013.
- Sub-module `fetch_pc_reg`:
  - PC register with async reset to `RESET_PC`.
  - Load port (redirect target) with priority over the increment port (+4).
- `fetch_ctrl` instantiates `fetch_pc_reg` and contains the FSM and the output register.

## Test plan
- **Reset/boot**: `RESET_PC`=32'h100, release `rst`, `imem_ready`=1, k=1 -> first `imem_req` with `imem_addr`=32'h100 on cycle 2. `instr_valid`=1 with `instr_pc`=32'h100, then 32'h104 two cycles later.
- **Stall hold**: stall asserted 3 cycles while `instr`=32'h00A00093 is valid -> `instr`/`instr_pc` unchanged, no `imem_req` until the cycle after stall drops.
- **Redirect during WAIT**: redirect to 32'h200 with a fetch of 32'h108 outstanding -> `flush` pulse next cycle, the 32'h108 response is discarded, and the next request has `imem_addr`=32'h200.
- **Redirect with rvalid same cycle, target 32'h203**: response is dropped, `instr_valid`=0, and the next `imem_addr`=32'h200.
- **Wrap and async reset**: PC=32'hFFFF_FFFC fetches, next `imem_addr`=32'h0. Assert `rst` mid-`WAIT` between clock edges -> all outputs take reset values immediately.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [2:0] {
    BOOT = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    DROP = 3'd4
  } fetch_state_t;

  localparam logic [31:0] INSTR_BYTES = 32'd4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  // Redirect targets are always word aligned; the low two bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: redirect load has priority over the +4 increment.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_pc,
  input  logic        inc,
  output logic [31:0] pc
);

  logic [31:0] pc_r;

  // PC update: load wins over increment, increment wraps modulo 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else if (load) begin
      pc_r <= align_word(load_pc);
    end else if (inc) begin
      pc_r <= pc_r + INSTR_BYTES;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, runs the imem handshake and holds one
// PC-tagged instruction for decode, discarding responses made stale by redirects.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        flush
);

  fetch_state_t state_r, state_s;
  logic [31:0]  pc_s;
  logic         redirect_s;
  logic         load_s;
  logic         valid_s;
  logic         instr_valid_r;
  logic [31:0]  instr_r;
  logic [31:0]  instr_pc_r;
  logic         flush_r;

  // Redirects are ignored during the boot cycle; a response is delivered only
  // when no redirect kills it in the same cycle.
  assign redirect_s = redirect && (state_r != BOOT);
  assign load_s     = (state_r == WAIT) && imem_rvalid && !redirect_s;

  fetch_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk     (clk),
    .rst     (rst),
    .load    (redirect_s),
    .load_pc (redirect_target),
    .inc     (load_s),
    .pc      (pc_s)
  );

  // Next-state decode; imem_req depends on registered state only.
  always_comb begin
    state_s  = state_r;
    imem_req = 1'b0;
    case (state_r)
      BOOT: begin
        state_s = REQ;
      end
      REQ: begin
        imem_req = 1'b1;
        if (redirect_s) begin
          state_s = imem_ready ? DROP : REQ;
        end else if (imem_ready) begin
          state_s = WAIT;
        end else begin
          state_s = REQ;
        end
      end
      WAIT: begin
        if (redirect_s) begin
          state_s = imem_rvalid ? REQ : DROP;
        end else if (imem_rvalid) begin
          state_s = stall ? HOLD : REQ;
        end else begin
          state_s = WAIT;
        end
      end
      HOLD: begin
        if (redirect_s || !stall) begin
          state_s = REQ;
        end else begin
          state_s = HOLD;
        end
      end
      DROP: begin
        // A redirect here only moves the PC; the stale response must still drain.
        if (imem_rvalid) begin
          state_s = REQ;
        end else begin
          state_s = DROP;
        end
      end
      default: begin
        state_s = BOOT;
      end
    endcase
  end

  // Output-register valid: kill on redirect, set on delivery, clear on consumption.
  always_comb begin
    valid_s = instr_valid_r;
    if (redirect_s) begin
      valid_s = 1'b0;
    end else if (load_s) begin
      valid_s = 1'b1;
    end else if (!stall) begin
      valid_s = 1'b0;
    end else begin
      valid_s = instr_valid_r;
    end
  end

  // State, instruction output register and flush pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= BOOT;
      instr_valid_r <= 1'b0;
      instr_r       <= NOP_INSTR;
      instr_pc_r    <= RESET_PC;
      flush_r       <= 1'b0;
    end else begin
      state_r       <= state_s;
      instr_valid_r <= valid_s;
      flush_r       <= redirect_s;
      if (load_s) begin
        instr_r    <= imem_rdata;
        instr_pc_r <= pc_s;
      end
    end
  end

  assign imem_addr   = pc_s;
  assign instr_valid = instr_valid_r;
  assign instr       = instr_r;
  assign instr_pc    = instr_pc_r;
  assign flush       = flush_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized traffic
// against a transaction-level model of fetch delivery and redirect kills.
module tb_fetch_ctrl;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        flush;

  fetch_ctrl #(.RESET_PC(RPC)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .flush           (flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          killed;
  } pend_t;

  pend_t       q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  logic [31:0] exp_addr;
  logic [31:0] exp_instr;
  logic [31:0] exp_pc;
  logic        exp_valid;
  logic        exp_flush;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0000_0104) return 32'h00A0_0093;
    return {a[29:0], 2'b11} ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  task automatic model_reset();
    q.delete();
    cyc       = 0;
    exp_addr  = RPC;
    exp_instr = NOP;
    exp_pc    = RPC;
    exp_valid = 1'b0;
    exp_flush = 1'b0;
  endtask

  // One clock: drive inputs (memory answers in order after its latency),
  // advance the model, then compare registered outputs after the edge.
  task automatic step(input logic st, input logic rd, input logic [31:0] tgt, input logic rdy);
    pend_t e;
    logic  resp, accept, delivered;
    e    = '{addr: 32'h0, due: 0, killed: 1'b0};
    resp = (q.size() > 0) && (q[0].due == cyc);
    stall           = st;
    redirect        = rd;
    redirect_target = tgt;
    imem_ready      = rdy;
    imem_rvalid     = resp;
    imem_rdata      = resp ? memf(q[0].addr) : $urandom;
    accept = imem_req && rdy;
    if (accept) begin
      chk("req_addr", imem_addr, exp_addr);
      chk("req_while_outstanding", 32'(q.size()), 32'd0);
    end
    if (resp) e = q.pop_front();
    delivered = resp && !e.killed && !rd;
    if (accept) q.push_back('{addr: imem_addr, due: cyc + int'($urandom_range(lat_max, lat_min)), killed: 1'b0});
    if (rd) foreach (q[i]) q[i].killed = 1'b1;
    if (delivered) exp_addr = e.addr + 32'd4;
    if (rd) exp_addr = {tgt[31:2], 2'b00};
    if (delivered) begin
      exp_valid = 1'b1;
      exp_instr = memf(e.addr);
      exp_pc    = e.addr;
    end else if (rd || !st) begin
      exp_valid = 1'b0;
    end
    exp_flush = rd;
    cyc++;
    @(negedge clk);
    chk1("instr_valid", instr_valid, exp_valid);
    chk("instr", instr, exp_instr);
    chk("instr_pc", instr_pc, exp_pc);
    chk1("flush", flush, exp_flush);
  endtask

  task automatic chk_reset_values(input string tag);
    chk1({tag, "_imem_req"}, imem_req, 1'b0);
    chk({tag, "_imem_addr"}, imem_addr, RPC);
    chk1({tag, "_instr_valid"}, instr_valid, 1'b0);
    chk({tag, "_instr"}, instr, NOP);
    chk({tag, "_instr_pc"}, instr_pc, RPC);
    chk1({tag, "_flush"}, flush, 1'b0);
  endtask

  initial begin
    bit found;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_values("reset");

    // Boot: BOOT cycle, then first request to RESET_PC, delivered k=1.
    rst = 1'b0;
    chk1("boot_no_req", imem_req, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk1("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 32'h0000_0100);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk1("first_valid", instr_valid, 1'b1);
    chk("first_pc", instr_pc, 32'h0000_0100);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("second_pc", instr_pc, 32'h0000_0104);
    chk1("hold_enter_no_req", imem_req, 1'b0);

    // Stall hold for three valid cycles.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1);
      chk("hold_instr", instr, 32'h00A0_0093);
      chk("hold_pc", instr_pc, 32'h0000_0104);
      chk1("hold_no_req", imem_req, 1'b0);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk1("release_req", imem_req, 1'b1);
    chk("release_addr", imem_addr, 32'h0000_0108);

    // Redirect while the 0x108 fetch is outstanding.
    lat_min = 2; lat_max = 2;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    chk1("drop_flush", flush, 1'b1);
    chk1("drop_no_req", imem_req, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk1("drop_discard_valid", instr_valid, 1'b0);
    chk1("drop_req", imem_req, 1'b1);
    chk("drop_addr", imem_addr, 32'h0000_0200);

    // Redirect coinciding with rvalid, unaligned target.
    lat_min = 1; lat_max = 1;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0203, 1'b1);
    chk1("same_cycle_valid", instr_valid, 1'b0);
    chk1("same_cycle_req", imem_req, 1'b1);
    chk("same_cycle_addr", imem_addr, 32'h0000_0200);

    // Randomized traffic.
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(99, 0) < 30, $urandom_range(99, 0) < 8,
           ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0 + ($urandom & 32'hF) : $urandom,
           $urandom_range(99, 0) < 65);
    end

    // Wrap at the top of the address space.
    lat_min = 1; lat_max = 1;
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (imem_req && imem_addr == 32'h0) found = 1'b1;
      else step(1'b0, 1'b0, 32'h0, 1'b1);
    end
    chk1("wrap_reached", found, 1'b1);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_prev_pc", instr_pc, 32'hFFFF_FFFC);

    // Asynchronous reset between edges with a fetch in flight.
    lat_min = 3; lat_max = 3;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    #2 rst = 1'b1;
    imem_rvalid = 1'b0;
    #1 chk_reset_values("async_reset");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    chk1("reboot_no_req", imem_req, 1'b0);
    lat_min = 1; lat_max = 1;
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);
    chk1("reboot_valid", instr_valid, 1'b1);
    chk("reboot_pc", instr_pc, 32'h0000_0100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
